// File: rtl/usb_data_buffer.sv
// Circular byte FIFO shared by the AHB subordinate and the USB RX/TX packet engines.
// One push and one pop may be serviced per cycle; both pop ports own a registered output.
module usb_data_buffer #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      clear,
   input  logic                      store_tx_data,
   input  logic [DATA_W-1:0]         tx_data,
   input  logic                      get_rx_data,
   output logic [DATA_W-1:0]         rx_data,
   input  logic                      store_rx_packet_data,
   input  logic [DATA_W-1:0]         rx_packet_data,
   input  logic                      get_tx_packet_data,
   output logic [DATA_W-1:0]         tx_packet_data,
   output logic [$clog2(DEPTH):0]    buffer_occupancy,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [DATA_W-1:0] tx_pkt_q, tx_pkt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              push_req;
   logic [DATA_W-1:0] push_byte;
   logic              pop_rx;
   logic              pop_tx;
   logic              pop_req;
   logic              pop_ok;
   logic              push_ok;
   logic              mem_we;
   logic [DATA_W-1:0] rd_byte;

   // Source arbitration: AHB push wins over USB RX push, AHB pop wins over USB TX pop.
   always_comb begin
      push_req  = store_tx_data | store_rx_packet_data;
      push_byte = store_tx_data ? tx_data : rx_packet_data;
      pop_rx    = get_rx_data;
      pop_tx    = get_tx_packet_data & ~get_rx_data;
      pop_req   = pop_rx | pop_tx;
      pop_ok    = pop_req & (count_q != '0);
      push_ok   = push_req & ((count_q != FULL) | pop_ok);
      rd_byte   = mem[rptr_q];
   end

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      rx_data_d = rx_data_q;
      tx_pkt_d  = tx_pkt_q;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      mem_we    = 1'b0;

      if (clear) begin
         wptr_d    = '0;
         rptr_d    = '0;
         count_d   = '0;
         rx_data_d = '0;
         tx_pkt_d  = '0;
      end else begin
         if (push_ok) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
         end
         ovf_d = (store_tx_data & store_rx_packet_data) | (push_req & ~push_ok);

         if (pop_req) begin
            if (pop_ok) begin
               rptr_d = rptr_q + 1'b1;
               if (pop_rx) rx_data_d = rd_byte;
               else        tx_pkt_d  = rd_byte;
            end else begin
               // Empty pop returns zero; a same-cycle push is not read through.
               unf_d = 1'b1;
               if (pop_rx) rx_data_d = '0;
               else        tx_pkt_d  = '0;
            end
         end

         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         rx_data_q <= '0;
         tx_pkt_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         rx_data_q <= rx_data_d;
         tx_pkt_q  <= tx_pkt_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // Storage carries no reset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wptr_q] <= push_byte;
   end

   assign rx_data          = rx_data_q;
   assign tx_packet_data   = tx_pkt_q;
   assign buffer_occupancy = count_q;
   assign overflow         = ovf_q;
   assign underflow        = unf_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer: one task per scenario, inline checks against hand-computed values.
module tb_usb_data_buffer;

   logic       clk;
   logic       n_rst;
   logic       clear;
   logic       store_tx_data;
   logic [7:0] tx_data;
   logic       get_rx_data;
   logic [7:0] rx_data;
   logic       store_rx_packet_data;
   logic [7:0] rx_packet_data;
   logic       get_tx_packet_data;
   logic [7:0] tx_packet_data;
   logic [6:0] buffer_occupancy;
   logic       overflow;
   logic       underflow;

   int tests;
   int fails;

   usb_data_buffer #(.DEPTH(64), .DATA_W(8)) dut (
      .clk                 (clk),
      .n_rst               (n_rst),
      .clear               (clear),
      .store_tx_data       (store_tx_data),
      .tx_data             (tx_data),
      .get_rx_data         (get_rx_data),
      .rx_data             (rx_data),
      .store_rx_packet_data(store_rx_packet_data),
      .rx_packet_data      (rx_packet_data),
      .get_tx_packet_data  (get_tx_packet_data),
      .tx_packet_data      (tx_packet_data),
      .buffer_occupancy    (buffer_occupancy),
      .overflow            (overflow),
      .underflow           (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle();
      clear                = 1'b0;
      store_tx_data        = 1'b0;
      tx_data              = 8'h00;
      get_rx_data          = 1'b0;
      store_rx_packet_data = 1'b0;
      rx_packet_data       = 8'h00;
      get_tx_packet_data   = 1'b0;
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      n_rst = 1'b0;
      #12;
      tests++;
      if ({rx_data, tx_packet_data, buffer_occupancy, overflow, underflow} !== 25'd0) begin
         fails++;
         $display("FAIL reset_outputs: rx=%h tx=%h occ=%0d ovf=%b unf=%b, required all 0",
                  rx_data, tx_packet_data, buffer_occupancy, overflow, underflow);
      end
      n_rst = 1'b1;
      step();
      get_rx_data = 1'b1;
      step();
      get_rx_data = 1'b0;
      tests++;
      if (rx_data !== 8'h00 || underflow !== 1'b1 || buffer_occupancy !== 7'd0) begin
         fails++;
         $display("FAIL empty_pop: rx=%h unf=%b occ=%0d, required 00 1 0", rx_data, underflow, buffer_occupancy);
      end
      step();
      tests++;
      if (underflow !== 1'b0) begin
         fails++;
         $display("FAIL underflow_pulse: unf=%b, required 0", underflow);
      end
   endtask

   task automatic test_ahb_to_usb();
      logic [7:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         store_tx_data = 1'b1;
         tx_data       = vals[i];
         step();
         tests++;
         if (buffer_occupancy !== 7'(i + 1)) begin
            fails++;
            $display("FAIL ahb_push_occ[%0d]: occ=%0d, required %0d", i, buffer_occupancy, i + 1);
         end
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         get_tx_packet_data = 1'b1;
         step();
         tests++;
         if (tx_packet_data !== vals[i] || buffer_occupancy !== 7'(2 - i)) begin
            fails++;
            $display("FAIL usb_tx_pop[%0d]: tx=%h occ=%0d, required %h %0d",
                     i, tx_packet_data, buffer_occupancy, vals[i], 2 - i);
         end
      end
      idle();
   endtask

   task automatic test_full_overflow();
      for (int i = 0; i < 64; i++) begin
         store_rx_packet_data = 1'b1;
         rx_packet_data       = 8'(i);
         step();
      end
      tests++;
      if (buffer_occupancy !== 7'd64 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL fill_64: occ=%0d ovf=%b, required 64 0", buffer_occupancy, overflow);
      end
      rx_packet_data = 8'hAA;
      step();
      idle();
      tests++;
      if (buffer_occupancy !== 7'd64 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL push_full: occ=%0d ovf=%b, required 64 1", buffer_occupancy, overflow);
      end
      for (int i = 0; i < 64; i++) begin
         get_rx_data = 1'b1;
         step();
         tests++;
         if (rx_data !== 8'(i)) begin
            fails++;
            $display("FAIL drain_rx[%0d]: rx=%h, required %h", i, rx_data, 8'(i));
         end
      end
      idle();
      tests++;
      if (buffer_occupancy !== 7'd0) begin
         fails++;
         $display("FAIL drained_occ: occ=%0d, required 0", buffer_occupancy);
      end
   endtask

   // Pointers start at 3 here, so the 64+1 byte drain wraps through slot 63.
   task automatic test_full_push_pop();
      for (int i = 0; i < 64; i++) begin
         store_tx_data = 1'b1;
         tx_data       = 8'h80 + 8'(i);
         step();
      end
      tx_data            = 8'h55;
      get_tx_packet_data = 1'b1;
      step();
      idle();
      tests++;
      if (tx_packet_data !== 8'h80 || buffer_occupancy !== 7'd64 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL full_push_pop: tx=%h occ=%0d ovf=%b, required 80 64 0",
                  tx_packet_data, buffer_occupancy, overflow);
      end
      for (int i = 1; i <= 64; i++) begin
         logic [7:0] exp;
         exp = (i == 64) ? 8'h55 : 8'h80 + 8'(i);
         get_tx_packet_data = 1'b1;
         step();
         tests++;
         if (tx_packet_data !== exp) begin
            fails++;
            $display("FAIL wrap_drain[%0d]: tx=%h, required %h", i, tx_packet_data, exp);
         end
      end
      idle();
      tests++;
      if (buffer_occupancy !== 7'd0) begin
         fails++;
         $display("FAIL wrap_occ: occ=%0d, required 0", buffer_occupancy);
      end
   endtask

   task automatic test_dual_push();
      for (int i = 0; i < 5; i++) begin
         store_tx_data = 1'b1;
         tx_data       = 8'h60 + 8'(i);
         step();
      end
      tx_data              = 8'h01;
      store_rx_packet_data = 1'b1;
      rx_packet_data       = 8'h02;
      step();
      idle();
      tests++;
      if (buffer_occupancy !== 7'd6 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL dual_push: occ=%0d ovf=%b, required 6 1", buffer_occupancy, overflow);
      end
      for (int i = 0; i < 6; i++) begin
         get_rx_data = 1'b1;
         step();
      end
      idle();
      tests++;
      if (rx_data !== 8'h01 || buffer_occupancy !== 7'd0) begin
         fails++;
         $display("FAIL dual_push_slot: rx=%h occ=%0d, required 01 0", rx_data, buffer_occupancy);
      end
   endtask

   task automatic test_back_to_back();
      store_tx_data = 1'b1;
      tx_data       = 8'hA1;
      step();
      tx_data            = 8'hA2;
      get_tx_packet_data = 1'b1;
      step();
      tests++;
      if (tx_packet_data !== 8'hA1 || buffer_occupancy !== 7'd1) begin
         fails++;
         $display("FAIL b2b_push_pop: tx=%h occ=%0d, required a1 1", tx_packet_data, buffer_occupancy);
      end
      store_tx_data = 1'b0;
      // Both pops high: only the AHB side is serviced, TX output holds.
      get_rx_data = 1'b1;
      step();
      idle();
      tests++;
      if (rx_data !== 8'hA2 || tx_packet_data !== 8'hA1 || buffer_occupancy !== 7'd0) begin
         fails++;
         $display("FAIL pop_priority: rx=%h tx=%h occ=%0d, required a2 a1 0",
                  rx_data, tx_packet_data, buffer_occupancy);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         store_tx_data = 1'b1;
         tx_data       = 8'hC0 + 8'(i);
         step();
      end
      idle();
      #2;
      n_rst = 1'b0;
      #1;
      tests++;
      if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00 || rx_data !== 8'h00) begin
         fails++;
         $display("FAIL async_reset: occ=%0d rx=%h tx=%h, required 0 00 00",
                  buffer_occupancy, rx_data, tx_packet_data);
      end
      n_rst = 1'b1;
      get_rx_data = 1'b1;
      step();
      idle();
      tests++;
      if (underflow !== 1'b1 || rx_data !== 8'h00) begin
         fails++;
         $display("FAIL post_reset_empty: unf=%b rx=%h, required 1 00", underflow, rx_data);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 12; i++) begin
         store_tx_data = 1'b1;
         tx_data       = 8'h70 + 8'(i);
         step();
      end
      idle();
      get_rx_data = 1'b1;
      step();
      idle();
      get_tx_packet_data = 1'b1;
      step();
      idle();
      tests++;
      if (rx_data !== 8'h70 || tx_packet_data !== 8'h71 || buffer_occupancy !== 7'd10) begin
         fails++;
         $display("FAIL pre_clear: rx=%h tx=%h occ=%0d, required 70 71 10",
                  rx_data, tx_packet_data, buffer_occupancy);
      end
      clear         = 1'b1;
      store_tx_data = 1'b1;
      tx_data       = 8'hEE;
      get_rx_data   = 1'b1;
      step();
      idle();
      tests++;
      if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00 || tx_packet_data !== 8'h00 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
         fails++;
         $display("FAIL clear: occ=%0d rx=%h tx=%h ovf=%b unf=%b, required 0 00 00 0 0",
                  buffer_occupancy, rx_data, tx_packet_data, overflow, underflow);
      end
      get_rx_data = 1'b1;
      step();
      idle();
      tests++;
      if (underflow !== 1'b1 || rx_data !== 8'h00 || buffer_occupancy !== 7'd0) begin
         fails++;
         $display("FAIL clear_then_pop: unf=%b rx=%h occ=%0d, required 1 00 0",
                  underflow, rx_data, buffer_occupancy);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_ahb_to_usb();
      test_full_overflow();
      test_full_push_pop();
      test_dual_push();
      test_back_to_back();
      test_async_reset();
      test_clear();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

64-byte circular FIFO shared between the AHB-Lite subordinate and the USB RX/TX packet engines. The AHB side pushes bytes to transmit (`store_tx_data`/`tx_data`) and pops bytes received (`get_rx_data`/`rx_data`). The USB side pushes received payload bytes and pops payload bytes for transmission. The block reports its fill level to the subordinate's status register as `buffer_occupancy`.

## Interface
Parameters:
- DEPTH, 64, entry count; must be a power of two; fixes pointer width at log2(DEPTH)=6.
- DATA_W, 8, byte width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous reset, active-low.
- clear  in  1  synchronous flush from the AHB subordinate (register 13 bit 0).
- store_tx_data  in  1  AHB-side push strobe, one byte per cycle high.
- tx_data  in  8  AHB-side push byte.
- get_rx_data  in  1  AHB-side pop strobe.
- rx_data  out  8  AHB-side pop byte, registered.
- store_rx_packet_data  in  1  USB RX push strobe.
- rx_packet_data  in  8  USB RX push byte.
- get_tx_packet_data  in  1  USB TX pop strobe.
- tx_packet_data  out  8  USB TX pop byte, registered.
- buffer_occupancy  out  7  byte count, range 0..64.
- overflow  out  1  one-cycle pulse when a push is dropped.
- underflow  out  1  one-cycle pulse when a pop hits an empty FIFO.

## Operation
- State: 64×8 storage array, 6-bit write pointer `wptr`, 6-bit read pointer `rptr`, 7-bit `count`. Pointers wrap from 63 to 0. The storage array is not reset.
- Push source select: `store_tx_data` has priority over `store_rx_packet_data`. If both are high, the RX byte is dropped and `overflow` pulses.
- Pop source select: if `get_rx_data` and `get_tx_packet_data` are both high, only `get_rx_data` is serviced. The TX pop is ignored and `tx_packet_data` holds.
- Push accepted when `count<64`, or when `count==64` with a pop serviced in the same cycle. On accept: `mem[wptr]<=byte`, `wptr++`.
- Push when full with no pop: byte dropped, pointers unchanged, `overflow`=1 for one cycle.
- Pop when `count>0`: the selected output register loads `mem[rptr]`, then `rptr++`.
- Pop when `count==0`: the selected output register loads 8'h00, `rptr` is unchanged, `underflow`=1 for one cycle. A push in the same cycle is still accepted; read-through does not occur.
- Count update: `count` +1 on accepted push only, −1 on successful pop only, unchanged when both happen.
- `buffer_occupancy = count`, driven directly from the register.
- `clear`: next edge sets `wptr`, `rptr` and `count` to 0, and sets `rx_data`, `tx_packet_data`, `overflow` and `underflow` to 0. Any push or pop in the same cycle is discarded.
- Output registers (`rx_data`, `tx_packet_data`) hold their value until the next serviced pop of their own port, a `clear`, or a reset.

## Timing
- Reset (asynchronous): `wptr`=`rptr`=0, `count`=0, `rx_data`=0, `tx_packet_data`=0, `overflow`=0, `underflow`=0.
- Pop latency is one cycle: with the strobe high in cycle N, the data is valid from the edge ending cycle N through at least cycle N+1. The subordinate samples `rx_data` in cycle N+1.
- Push-to-pop latency: a byte written at edge N can be popped with a strobe in cycle N+1.
- `buffer_occupancy` reflects every push and pop one edge after its strobe.
- Back-to-back strobes sustain 1 byte/cycle on each side concurrently.
- A reset asserted mid-transfer discards all contents immediately; no partial state survives.

## Test plan
- Reset then idle: all outputs 0, `buffer_occupancy`=0. Pop once: `rx_data`=0x00, `underflow` pulses, `buffer_occupancy` stays 0.
- AHB pushes 0x11,0x22,0x33 on consecutive cycles, then USB TX pops 3 times: `tx_packet_data`=0x11,0x22,0x33 one cycle after each strobe; occupancy goes 1,2,3, then 2,1,0.
- RX pushes 64 bytes 0x00..0x3F, then pushes 0xAA: occupancy=64 and `overflow` pulses. AHB pops 64: `rx_data` sequence 0x00..0x3F, occupancy 0.
- Fill to 64, then push 0x55 and pop in the same cycle: pop returns the oldest byte, occupancy stays 64, no `overflow`. Draining continues through the pointer wrap and ends with 0x55.
- Simultaneous `store_tx_data`(0x01) and `store_rx_packet_data`(0x02) at count 5: count becomes 6, `overflow` pulses, and a later pop of that slot returns 0x01.
- With 10 bytes stored, assert `clear` together with a push and a pop: next cycle occupancy=0, both data outputs=0, and a following pop underflows.
